// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int SUB_W = 4;
endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int N = SUB_W
);
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow_out;

    modport master (output start, a_in, b_in, input busy, done, diff, borrow_out);
    modport slave  (input start, a_in, b_in, output busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor built from two half subtractors; the per-bit cell of the serial datapath.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);
    assign d  = a ^ b;
    assign bo = ~a & b;
endmodule

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1, b1, b2;

    half_subtractor u_hs0 (.a(a),  .b(b),   .d(d1), .bo(b1));
    half_subtractor u_hs1 (.a(d1), .b(bin), .d(d),  .bo(b2));

    assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_SAT_EN to clamp the result to 0 when the final borrow is set.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = SUB_W
) (
    input  logic                clk,
    input  logic                reset_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  a_sr, b_sr, r_sr;
    logic [N-1:0]  diff_q;
    logic          bff, borrow_q, busy_q, done_q;
    logic [CW-1:0] cnt;
    logic          d, bo;
    logic [N-1:0]  res_nxt;

    full_subtractor u_cell (.a(a_sr[0]), .b(b_sr[0]), .bin(bff), .d(d), .bout(bo));

    // The bit produced this cycle lands in the MSB; on the last edge this is the full result.
    assign res_nxt = {d, r_sr[N-1:1]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            r_sr     <= '0;
            bff      <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a_in;
                        b_sr   <= bus.b_in;
                        r_sr   <= '0;
                        bff    <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= res_nxt;
                    bff  <= bo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
`ifdef SERIAL_SUB_SAT_EN
                        diff_q <= bo ? '0 : res_nxt;
`else
                        diff_q <= res_nxt;
`endif
                        borrow_q <= bo;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule
